seg_frame_decoder: RTL and testbench

//  Receive-side counterpart of the hex-to-7-segment encoder: samples a scanned, multiplexed

---
 rtl/seg_frame_decoder.sv | 182 ++++++++++++++++++
 tb/tb_seg_frame_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_frame_decoder
//  Description : Samples a scanned, multiplexed active-low 7-segment bus and
//                recovers the hex nibble and decimal point of every digit.
//                A digit is captured after its segment pattern has been held
//                steady for STABLE_CYCLES samples. The module emits a
//                one-cycle frame pulse once every digit has been captured,
//                and an error pulse whenever more than one anode is active.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_frame_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              segs,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   invalid_out,
    output logic                    frame_valid,
    output logic                    err_pulse
);

    localparam int                    CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int                    SMP_W  = NUM_DIGITS + 8;
    localparam logic [NUM_DIGITS-1:0] ONE_D  = NUM_DIGITS'(1);
    localparam logic [CNT_W-1:0]      C_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      C_FULL = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [SMP_W-1:0]    r_smp;
    logic [SMP_W-1:0]    r_prv;
    logic [NUM_DIGITS-1:0] r_seen;

    logic [NUM_DIGITS-1:0] w_smp_an;
    logic [NUM_DIGITS-1:0] w_prv_an;
    logic [7:0]            w_smp_segs;
    logic [NUM_DIGITS-1:0] w_low;       // one bit per enabled anode in smp
    logic [NUM_DIGITS-1:0] w_prv_low;
    logic                  w_blank;
    logic                  w_legal;
    logic                  w_multi;
    logic                  w_prv_multi;
    logic                  w_changed;
    logic                  w_capture;
    logic                  w_glyph_hit;
    logic [3:0]            w_glyph_nib;
    logic [NUM_DIGITS-1:0] w_seen_next;

    assign w_smp_an   = r_smp[SMP_W-1:8];
    assign w_prv_an   = r_prv[SMP_W-1:8];
    assign w_smp_segs = r_smp[7:0];
    assign w_low      = ~w_smp_an;
    assign w_prv_low  = ~w_prv_an;

    // Anode classification: blank (no digit), exactly one digit, or several
    assign w_blank     = (w_low == '0);
    assign w_legal     = !w_blank && ((w_low & (w_low - ONE_D)) == '0);
    assign w_multi     = !w_blank && !w_legal;
    assign w_prv_multi = (w_prv_low != '0) &&
                         ((w_prv_low & (w_prv_low - ONE_D)) != '0);

    // Any bit difference, including the decimal point, restarts the dwell
    assign w_changed = (r_smp != r_prv);

    // Capture on the sample that completes the required run of identical ones
    assign w_capture = (r_state == ST_COUNT) && !w_changed && (r_cnt == C_LAST);

    // Glyph lookup on segments g..a; decimal point is ignored here
    always_comb begin
        w_glyph_hit = 1'b1;
        w_glyph_nib = 4'h0;
        case (w_smp_segs[6:0])
            7'h40: w_glyph_nib = 4'h0;
            7'h79: w_glyph_nib = 4'h1;
            7'h24: w_glyph_nib = 4'h2;
            7'h30: w_glyph_nib = 4'h3;
            7'h19: w_glyph_nib = 4'h4;
            7'h12: w_glyph_nib = 4'h5;
            7'h02: w_glyph_nib = 4'h6;
            7'h78: w_glyph_nib = 4'h7;
            7'h00: w_glyph_nib = 4'h8;
            7'h18: w_glyph_nib = 4'h9;
            7'h08: w_glyph_nib = 4'hA;
            7'h03: w_glyph_nib = 4'hB;
            7'h46: w_glyph_nib = 4'hC;
            7'h21: w_glyph_nib = 4'hD;
            7'h06: w_glyph_nib = 4'hE;
            7'h0E: w_glyph_nib = 4'hF;
            default: w_glyph_hit = 1'b0;
        endcase
    end

    // Seen mask: cleared on the frame pulse edge, then the current capture ORed in
    always_comb begin
        w_seen_next = (&r_seen) ? '0 : r_seen;
        if (w_capture) begin
            w_seen_next = w_seen_next | w_low;
        end
    end

    // Input stage: register the bus once and keep the previous sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_smp <= '1;
            r_prv <= '1;
        end else begin
            r_smp <= {an, segs};
            r_prv <= r_smp;
        end
    end

    // Dwell FSM with registered capture, frame and error outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_seen      <= '0;
            digits_out  <= '0;
            dp_out      <= '0;
            invalid_out <= '0;
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
        end else begin
            frame_valid <= &r_seen;
            err_pulse   <= w_multi && !w_prv_multi;
            r_seen      <= w_seen_next;

            case (r_state)
                ST_IDLE: begin
                    if (w_changed && w_legal) begin
                        r_state <= ST_COUNT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (w_changed) begin
                        r_state <= w_legal ? ST_COUNT : ST_IDLE;
                        r_cnt   <= w_legal ? CNT_W'(1) : '0;
                    end else if (r_cnt == C_LAST) begin
                        r_state <= ST_HELD;
                        r_cnt   <= C_FULL;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (w_changed) begin
                        r_state <= w_legal ? ST_COUNT : ST_IDLE;
                        r_cnt   <= w_legal ? CNT_W'(1) : '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase

            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_capture && w_low[i]) begin
                    dp_out[i]      <= ~w_smp_segs[7];
                    invalid_out[i] <= ~w_glyph_hit;
                    if (w_glyph_hit) begin
                        digits_out[4*i +: 4] <= w_glyph_nib;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_frame_decoder
//  Description : Self-checking bench for seg_frame_decoder. A run-length
//                reference model over the driven bus predicts every output
//                on every cycle; directed scenarios are followed by random
//                dwells.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_frame_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    segs = 8'hFF;
    logic [ND-1:0] an = '1;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0] dp_out;
    logic [ND-1:0] invalid_out;
    logic          frame_valid;
    logic          err_pulse;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int err_cnt = 0;

    seg_frame_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .segs        (segs),
        .an          (an),
        .digits_out  (digits_out),
        .dp_out      (dp_out),
        .invalid_out (invalid_out),
        .frame_valid (frame_valid),
        .err_pulse   (err_pulse)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state (values visible after the most recent edge)
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_inv, m_seen;
    logic        m_fv, m_err;
    // Effects decided by the latest sample, visible after the next edge
    bit          p_cap, p_err;
    logic [11:0] p_val;
    // Run-length tracker of identical samples since reset
    logic [11:0] run_val;
    int          run_len;
    bit          prev_multi;

    function automatic int zeros(input logic [3:0] a);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_dig = '0; m_dp = '0; m_inv = '0; m_seen = '0; m_fv = 0; m_err = 0;
        p_cap = 0; p_err = 0; p_val = '0; run_val = '0; run_len = 0; prev_multi = 0;
    endtask

    task automatic model_edge(input logic [3:0] a, input logic [7:0] s, input logic r);
        logic [11:0] cur;
        int k;
        int hit;
        if (!r) begin
            model_reset();
            return;
        end
        // Outputs produced by this edge
        m_fv = (m_seen == 4'hF);
        if (m_fv) m_seen = '0;
        m_err = p_err;
        if (p_cap) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (!p_val[8+i]) k = i;
            hit = -1;
            for (int g = 0; g < 16; g++) if (glyph[g] == p_val[6:0]) hit = g;
            m_dp[k] = ~p_val[7];
            if (hit >= 0) begin
                m_dig[4*k +: 4] = 4'(hit);
                m_inv[k] = 1'b0;
            end else begin
                m_inv[k] = 1'b1;
            end
            m_seen[k] = 1'b1;
        end
        // Sample taken at this edge
        cur = {a, s};
        if (run_len > 0 && cur == run_val) run_len++;
        else begin
            run_len = 1;
            run_val = cur;
        end
        p_cap = (zeros(a) == 1) && (run_len == SC);
        p_val = cur;
        p_err = (zeros(a) > 1) && !prev_multi;
        prev_multi = (zeros(a) > 1);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [3:0] a, input logic [7:0] s, input logic r);
        an = a;
        segs = s;
        rst_n = r;
        @(posedge clk);
        model_edge(a, s, r);
        #1;
        chk("digits", digits_out, m_dig);
        chk("dp", 16'(dp_out), 16'(m_dp));
        chk("invalid", 16'(invalid_out), 16'(m_inv));
        chk("frame_valid", 16'(frame_valid), 16'(m_fv));
        chk("err_pulse", 16'(err_pulse), 16'(m_err));
        if (frame_valid === 1'b1) fv_cnt++;
        if (err_pulse === 1'b1) err_cnt++;
    endtask

    task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) tick(a, s, 1'b1);
    endtask

    task automatic do_reset();
        tick(4'hF, 8'hFF, 1'b0);
        tick(4'hF, 8'hFF, 1'b0);
    endtask

    initial begin
        logic [3:0] ra;
        logic [7:0] rs;
        int sel;

        model_reset();

        // Reset state
        do_reset();
        chk("reset_digits", digits_out, 16'h0000);
        chk("reset_flags", {dp_out, invalid_out, 6'b0, frame_valid, err_pulse}, 16'h0000);

        // Full scan of four legal digits
        fv_cnt = 0;
        dwell(4'hE, 8'hB0, 6);
        dwell(4'hD, 8'hF9, 6);
        dwell(4'hB, 8'hC0, 6);
        dwell(4'h7, 8'h8E, 6);
        dwell(4'hF, 8'hFF, 2);
        chk("scan_digits", digits_out, 16'hF013);
        chk("scan_invalid", 16'(invalid_out), 16'h0);
        chk("scan_dp", 16'(dp_out), 16'h0);
        chk("scan_frames", 16'(fv_cnt), 16'd1);

        // Short dwell never captures
        do_reset();
        dwell(4'hE, 8'hA4, 3);
        dwell(4'hF, 8'hFF, 4);
        chk("glitch_digits", digits_out, 16'h0000);

        // Illegal glyph keeps the nibble and flags the digit
        dwell(4'hE, 8'hB0, 6);
        dwell(4'hE, 8'hFF, 6);
        chk("inv_flag", 16'(invalid_out[0]), 16'h1);
        chk("inv_nibble", 16'(digits_out[3:0]), 16'h3);
        dwell(4'hE, 8'hB0, 6);
        chk("inv_clear", 16'(invalid_out[0]), 16'h0);

        // Two anodes at once: one error pulse, nothing captured
        err_cnt = 0;
        dwell(4'hC, 8'hB0, 6);
        dwell(4'hF, 8'hFF, 2);
        chk("multi_err_count", 16'(err_cnt), 16'd1);
        chk("multi_digits", digits_out, 16'h0003);

        // Reset mid-frame discards the partial frame
        dwell(4'hD, 8'hF9, 6);
        tick(4'hF, 8'hFF, 1'b0);
        chk("midreset_digits", digits_out, 16'h0000);
        fv_cnt = 0;
        dwell(4'hE, 8'hB0, 6);
        dwell(4'hD, 8'hF9, 6);
        dwell(4'hB, 8'hC0, 6);
        chk("midreset_no_frame", 16'(fv_cnt), 16'd0);
        dwell(4'h7, 8'h8E, 6);
        chk("midreset_frame", 16'(fv_cnt), 16'd1);

        // Lit decimal point with glyph F
        dwell(4'hD, 8'h0E, 6);
        chk("dp_nibble", 16'(digits_out[7:4]), 16'hF);
        chk("dp_lit", 16'(dp_out[1]), 16'h1);
        chk("dp_valid", 16'(invalid_out[1]), 16'h0);

        // Random dwells against the reference model
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7) begin
                ra = ~(4'b0001 << $urandom_range(0, 3));
            end else if (sel < 9) begin
                ra = 4'hF;
            end else begin
                ra = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 4) == 0) rs = 8'($urandom);
            else rs = {1'($urandom), glyph[$urandom_range(0, 15)]};
            dwell(ra, rs, int'($urandom_range(1, 7)));
            if ($urandom_range(0, 39) == 0) tick(4'hF, 8'hFF, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
